alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Single-clock controller that sequences the register-file + ALU datapath one operation at a time. It accepts commands (source regs A/B, destination reg, ALU opcode) through a valid/ready handshake into a small FIFO. It drives read addresses, opcode, ALU enable and write-back enable, then reports each completed result with its flags. It replaces manual stepping of the separate register and ALU clocks with fixed per-operation phases.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
ADDR_W, 5, register address width
OP_W, 4, ALU opcode width
DATA_W, 32, ALU result width

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept (count < FIFO_DEPTH)
cmd_ra  input  ADDR_W  source register A
cmd_rb  input  ADDR_W  source register B
cmd_rd  input  ADDR_W  destination register
cmd_op  input  OP_W  ALU opcode
r_addr_a  output  ADDR_W  register-file read address A
r_addr_b  output  ADDR_W  register-file read address B
w_addr  output  ADDR_W  register-file write address
alu_op  output  OP_W  opcode to ALU
alu_en  output  1  ALU evaluate strobe
w_en  output  1  register-file write strobe (write data = ALU result)
res_in  input  DATA_W  ALU result
flags_in  input  4  ALU flags
done  output  1  one-cycle completion pulse
done_res  output  DATA_W  result of last completed op
done_flags  output  4  flags of last completed op
busy  output  1  FSM not IDLE or FIFO non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, any state): FSM->IDLE, FIFO emptied, all registered outputs 0 (addresses, alu_op, alu_en, w_en, done, done_res, done_flags); fifo_count 0, busy 0, cmd_ready 1. In-flight op aborted, no write-back.
- Push when cmd_valid && cmd_ready at a clock edge. cmd_ready depends only on the current count, so when full it stays low even if a pop occurs in the same cycle. Same-cycle push and pop when not full: count unchanged.
- FIFO circular, wrap-around of read/write pointers; order preserved.
- FSM: IDLE, READ, EXEC, WB; each state lasts exactly 1 cycle.
  - IDLE: if FIFO non-empty, pop head into current-op regs -> READ; else stay.
  - READ: r_addr_a/r_addr_b/w_addr/alu_op driven from current op (registered, stable through EXEC and WB); alu_en=0, w_en=0. -> EXEC.
  - EXEC: alu_en=1 for this cycle only. -> WB.
  - WB: capture res_in/flags_in; w_en=1 iff w_addr != 0 (x0 writes suppressed); done=1 next cycle with done_res/done_flags updated. If FIFO non-empty, pop in WB -> READ directly; else -> IDLE.
- Latency: command pushed at edge T is in READ at T+2 (empty FIFO, IDLE), EXEC at T+3, WB at T+4, done high during T+5. Back-to-back throughput 1 op per 3 cycles.
- done_res/done_flags hold until the next completion.
- Dependent ops (rd of op N = ra/rb of op N+1) are correct without stalls: write occurs in WB, next READ is at least one edge later.
- alu_en and w_en never high in the same cycle.

Test Plan:
- Reset then idle 10 cycles -> cmd_ready=1, busy=0, alu_en=w_en=done=0, fifo_count=0.
- Push {ra=1, rb=2, rd=3, op=ADD} at T, res_in=0x0000_0007 in WB -> READ at T+2, alu_en at T+3, w_en with w_addr=3 at T+4, done at T+5 with done_res=7.
- Push 4 commands back-to-back while sequencer stalled on first -> cmd_ready low at count 4, 5th cmd_valid not accepted; all 4 complete in order, done pulses 3 cycles apart.
- Command with rd=0 -> full sequence, done pulses, w_en stays 0.
- Pointer wrap: push/pop 10 commands continuously -> results in push order, fifo_count never exceeds 4.
- Assert rst during EXEC with 2 queued -> outputs 0 immediately, no w_en, no done; after release fifo_count=0 and queued ops discarded.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command/datapath bundle between a command source and alu_op_sequencer.
// master: issues commands and returns ALU results/flags.
// slave : the sequencer; drives register-file addresses, ALU strobes and
//         completion status.
interface alu_op_sequencer_if #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned OP_W       = 4,
    parameter int unsigned DATA_W     = 32
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    // command handshake
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_ra;
    logic [ADDR_W-1:0] cmd_rb;
    logic [ADDR_W-1:0] cmd_rd;
    logic [OP_W-1:0]   cmd_op;

    // datapath control
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [ADDR_W-1:0] w_addr;
    logic [OP_W-1:0]   alu_op;
    logic              alu_en;
    logic              w_en;
    logic [DATA_W-1:0] res_in;
    logic [3:0]        flags_in;

    // completion and status
    logic              done;
    logic [DATA_W-1:0] done_res;
    logic [3:0]        done_flags;
    logic              busy;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output cmd_valid, cmd_ra, cmd_rb, cmd_rd, cmd_op, res_in, flags_in,
        input  cmd_ready, r_addr_a, r_addr_b, w_addr, alu_op, alu_en, w_en,
               done, done_res, done_flags, busy, fifo_count
    );

    modport slave (
        input  cmd_valid, cmd_ra, cmd_rb, cmd_rd, cmd_op, res_in, flags_in,
        output cmd_ready, r_addr_a, r_addr_b, w_addr, alu_op, alu_en, w_en,
               done, done_res, done_flags, busy, fifo_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences the register-file + ALU datapath one queued operation at a time:
// READ (addresses/opcode presented), EXEC (alu_en), WB (w_en unless rd==0),
// followed by a one-cycle done pulse carrying the captured result and flags.
// Ports: clk, rst (async, active-high), bus (alu_op_sequencer_if.slave).
module alu_op_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned OP_W       = 4,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W-1:0] rd;
        logic [OP_W-1:0]   op;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t            state_q, state_d;
    cmd_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    cmd_t              cmd_in;
    cmd_t              cur_q, cur_d;
    logic              alu_en_q, alu_en_d;
    logic              w_en_q, w_en_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] done_res_q, done_res_d;
    logic [3:0]        done_flags_q, done_flags_d;
    logic              ready;
    logic              fifo_empty;
    logic              push, pop;

    // Ready is a function of occupancy only, so a full FIFO refuses a push
    // even in a cycle where the sequencer pops.
    assign ready      = (count_q < CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus.cmd_valid && ready;
    assign cmd_in     = '{ra: bus.cmd_ra, rb: bus.cmd_rb, rd: bus.cmd_rd, op: bus.cmd_op};

    // Command storage; contents need no reset, occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cmd_in;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            alu_en_q     <= 1'b0;
            w_en_q       <= 1'b0;
            done_q       <= 1'b0;
            done_res_q   <= '0;
            done_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            alu_en_q     <= alu_en_d;
            w_en_q       <= w_en_d;
            done_q       <= done_d;
            done_res_q   <= done_res_d;
            done_flags_q <= done_flags_d;
        end
    end

    // Next state and next output values; strobes are decoded from the state
    // being entered so they are high exactly while that state is current.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        cur_d        = cur_q;
        done_d       = 1'b0;
        done_res_d   = done_res_q;
        done_flags_d = done_flags_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = READ;
                end
            end
            READ: state_d = EXEC;
            EXEC: state_d = WB;
            WB: begin
                done_d       = 1'b1;
                done_res_d   = bus.res_in;
                done_flags_d = bus.flags_in;
                // Chain straight into the next op to sustain one op per 3 cycles.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            cur_d = fifo_mem[rd_ptr_q];
        end
        alu_en_d = (state_d == EXEC);
        // Writes to x0 are suppressed.
        w_en_d   = (state_d == WB) && (cur_q.rd != '0);
    end

    assign bus.cmd_ready  = ready;
    assign bus.fifo_count = count_q;
    assign bus.busy       = (state_q != IDLE) || !fifo_empty;
    assign bus.r_addr_a   = cur_q.ra;
    assign bus.r_addr_b   = cur_q.rb;
    assign bus.w_addr     = cur_q.rd;
    assign bus.alu_op     = cur_q.op;
    assign bus.alu_en     = alu_en_q;
    assign bus.w_en       = w_en_q;
    assign bus.done       = done_q;
    assign bus.done_res   = done_res_q;
    assign bus.done_flags = done_flags_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed vector table, multi-cycle
// corner sequences and randomized traffic against a schedule-based model.
module tb_alu_op_sequencer;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W-1:0] rd;
        logic [OP_W-1:0]   op;
    } tb_cmd_t;

    // Accepted command with its push edge and the cycle its READ phase starts.
    typedef struct {
        tb_cmd_t c;
        int      push_c;
        int      read_c;
    } op_rec_t;

    typedef struct {
        logic              v;
        tb_cmd_t           c;
        logic [DATA_W-1:0] res;
        logic [3:0]        flg;
        logic              e_ready;
        logic              e_busy;
        logic [CNT_W-1:0]  e_cnt;
        logic              e_alu;
        logic              e_wen;
        logic [ADDR_W-1:0] e_waddr;
        logic [ADDR_W-1:0] e_ra;
        logic              e_done;
        logic [DATA_W-1:0] e_dres;
        logic [3:0]        e_dflg;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .OP_W(OP_W), .DATA_W(DATA_W)) bus ();

    alu_op_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .OP_W(OP_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_read;
    int dut_done_cnt;
    int max_cnt;
    op_rec_t           ops[$];
    logic [DATA_W-1:0] res_hist[int];
    logic [3:0]        flg_hist[int];
    vec_t              vec[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic tb_cmd_t mk_cmd(input int ra, input int rb, input int rd, input int op);
        tb_cmd_t c;
        c.ra = ADDR_W'(ra);
        c.rb = ADDR_W'(rb);
        c.rd = ADDR_W'(rd);
        c.op = OP_W'(op);
        return c;
    endfunction

    function automatic tb_cmd_t rand_cmd();
        return mk_cmd(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
    endfunction

    function automatic vec_t mk_vec(input logic v, input tb_cmd_t c, input logic [DATA_W-1:0] res,
                                    input logic [3:0] flg, input logic rdy, input logic busy,
                                    input int cnt, input logic alu, input logic wen, input int waddr,
                                    input int ra, input logic dn, input logic [DATA_W-1:0] dres,
                                    input logic [3:0] dflg);
        vec_t r;
        r.v = v; r.c = c; r.res = res; r.flg = flg;
        r.e_ready = rdy; r.e_busy = busy; r.e_cnt = CNT_W'(cnt);
        r.e_alu = alu; r.e_wen = wen; r.e_waddr = ADDR_W'(waddr); r.e_ra = ADDR_W'(ra);
        r.e_done = dn; r.e_dres = dres; r.e_dflg = dflg;
        return r;
    endfunction

    task automatic drive(input logic v, input tb_cmd_t c, input logic [DATA_W-1:0] res, input logic [3:0] flg);
        bus.cmd_valid = v;
        bus.cmd_ra    = c.ra;
        bus.cmd_rb    = c.rb;
        bus.cmd_rd    = c.rd;
        bus.cmd_op    = c.op;
        bus.res_in    = res;
        bus.flags_in  = flg;
    endtask

    task automatic model_reset();
        ops.delete();
        res_hist.delete();
        flg_hist.delete();
        cyc          = 0;
        last_read    = -100;
        dut_done_cnt = 0;
        max_cnt      = 0;
    endtask

    // Leaves the bench #1 after a clock edge with reset released; cycle 0 is
    // the current cycle.
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: compare DUT outputs with the schedule model, then apply inputs.
    // Each op occupies READ/EXEC/WB at read_c, read_c+1, read_c+2 and pulses done
    // at read_c+3; it leaves the FIFO at read_c.
    task automatic step(input logic v, input tb_cmd_t c, input logic [DATA_W-1:0] res, input logic [3:0] flg);
        int                cnt;
        logic              e_alu, e_wen, e_done, active, e_ready;
        tb_cmd_t           e_cur;
        logic [DATA_W-1:0] e_res;
        logic [3:0]        e_flg;
        op_rec_t           rec;
        cnt = 0; e_alu = 1'b0; e_wen = 1'b0; e_done = 1'b0; active = 1'b0;
        e_cur = '0; e_res = '0; e_flg = '0;
        foreach (ops[i]) begin
            if (ops[i].push_c <= cyc) cnt++;
            if (ops[i].read_c <= cyc) begin
                cnt--;
                e_cur = ops[i].c;
            end
            if (cyc >= ops[i].read_c && cyc <= ops[i].read_c + 2) active = 1'b1;
            if (cyc == ops[i].read_c + 1) e_alu = 1'b1;
            if (cyc == ops[i].read_c + 2 && ops[i].c.rd != '0) e_wen = 1'b1;
            if (cyc == ops[i].read_c + 3) e_done = 1'b1;
            if (cyc >= ops[i].read_c + 3) begin
                e_res = res_hist[ops[i].read_c + 2];
                e_flg = flg_hist[ops[i].read_c + 2];
            end
        end
        e_ready = (cnt < int'(FIFO_DEPTH));

        chk("cmd_ready",  64'(bus.cmd_ready),  64'(e_ready));
        chk("busy",       64'(bus.busy),       64'(active || cnt != 0));
        chk("fifo_count", 64'(bus.fifo_count), 64'(cnt));
        chk("r_addr_a",   64'(bus.r_addr_a),   64'(e_cur.ra));
        chk("r_addr_b",   64'(bus.r_addr_b),   64'(e_cur.rb));
        chk("w_addr",     64'(bus.w_addr),     64'(e_cur.rd));
        chk("alu_op",     64'(bus.alu_op),     64'(e_cur.op));
        chk("alu_en",     64'(bus.alu_en),     64'(e_alu));
        chk("w_en",       64'(bus.w_en),       64'(e_wen));
        chk("done",       64'(bus.done),       64'(e_done));
        chk("done_res",   64'(bus.done_res),   64'(e_res));
        chk("done_flags", 64'(bus.done_flags), 64'(e_flg));
        chk("alu_w_excl", 64'(bus.alu_en & bus.w_en), 64'(0));
        if (bus.done === 1'b1) dut_done_cnt++;
        if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);

        drive(v, c, res, flg);
        res_hist[cyc] = res;
        flg_hist[cyc] = flg;
        if (v && e_ready) begin
            rec.c      = c;
            rec.push_c = cyc + 1;
            rec.read_c = (last_read + 3 > cyc + 2) ? last_read + 3 : cyc + 2;
            last_read  = rec.read_c;
            ops.push_back(rec);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(1'b0, rand_cmd(), DATA_W'($urandom), 4'($urandom));
    endtask

    initial begin
        tb_cmd_t ca, cb, cz;
        int      pct;
        rst = 1'b1;
        drive(1'b0, '0, '0, '0);
        ca = mk_cmd(1, 2, 3, 0);
        cb = mk_cmd(4, 5, 0, 2);
        cz = '0;

        // Single ADD with rd=3, then an op targeting x0.
        vec[0]  = mk_vec(1, ca, 32'h1111, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'h0);
        vec[1]  = mk_vec(0, cz, 32'h2222, 4'h0, 1, 1, 1, 0, 0, 0, 0, 0, 32'h0, 4'h0);
        vec[2]  = mk_vec(0, cz, 32'h3333, 4'h0, 1, 1, 0, 0, 0, 3, 1, 0, 32'h0, 4'h0);
        vec[3]  = mk_vec(0, cz, 32'h4444, 4'h0, 1, 1, 0, 1, 0, 3, 1, 0, 32'h0, 4'h0);
        vec[4]  = mk_vec(0, cz, 32'h7,    4'h2, 1, 1, 0, 0, 1, 3, 1, 0, 32'h0, 4'h0);
        vec[5]  = mk_vec(0, cz, 32'h5555, 4'hF, 1, 0, 0, 0, 0, 3, 1, 1, 32'h7, 4'h2);
        vec[6]  = mk_vec(1, cb, 32'h6666, 4'h0, 1, 0, 0, 0, 0, 3, 1, 0, 32'h7, 4'h2);
        vec[7]  = mk_vec(0, cz, 32'h7777, 4'h0, 1, 1, 1, 0, 0, 3, 1, 0, 32'h7, 4'h2);
        vec[8]  = mk_vec(0, cz, 32'h8888, 4'h0, 1, 1, 0, 0, 0, 0, 4, 0, 32'h7, 4'h2);
        vec[9]  = mk_vec(0, cz, 32'h9999, 4'h0, 1, 1, 0, 1, 0, 0, 4, 0, 32'h7, 4'h2);
        vec[10] = mk_vec(0, cz, 32'hDEADBEEF, 4'h9, 1, 1, 0, 0, 0, 0, 4, 0, 32'h7, 4'h2);
        vec[11] = mk_vec(0, cz, 32'hAAAA, 4'h0, 1, 0, 0, 0, 0, 0, 4, 1, 32'hDEADBEEF, 4'h9);
        vec[12] = mk_vec(0, cz, 32'hBBBB, 4'h0, 1, 0, 0, 0, 0, 0, 4, 0, 32'hDEADBEEF, 4'h9);

        // Reset then idle.
        do_reset();
        idle_steps(10);

        // Directed vector table.
        do_reset();
        foreach (vec[i]) begin
            chk("vec_ready",  64'(bus.cmd_ready),  64'(vec[i].e_ready));
            chk("vec_busy",   64'(bus.busy),       64'(vec[i].e_busy));
            chk("vec_count",  64'(bus.fifo_count), 64'(vec[i].e_cnt));
            chk("vec_alu_en", 64'(bus.alu_en),     64'(vec[i].e_alu));
            chk("vec_w_en",   64'(bus.w_en),       64'(vec[i].e_wen));
            chk("vec_w_addr", 64'(bus.w_addr),     64'(vec[i].e_waddr));
            chk("vec_r_addr_a", 64'(bus.r_addr_a), 64'(vec[i].e_ra));
            chk("vec_done",   64'(bus.done),       64'(vec[i].e_done));
            chk("vec_done_res", 64'(bus.done_res), 64'(vec[i].e_dres));
            chk("vec_done_flags", 64'(bus.done_flags), 64'(vec[i].e_dflg));
            drive(vec[i].v, vec[i].c, vec[i].res, vec[i].flg);
            cyc = i;
            @(posedge clk);
            #1;
        end

        // Saturate the FIFO with cmd_valid held high, then drain.
        do_reset();
        for (int k = 0; k < 12; k++) step(1'b1, rand_cmd(), DATA_W'($urandom), 4'($urandom));
        idle_steps(30);
        chk("sat_max_count", 64'(max_cnt), 64'(FIFO_DEPTH));
        chk("sat_done_total", 64'(dut_done_cnt), 64'(ops.size()));

        // Ten commands pushed continuously through the wrapping pointers.
        do_reset();
        for (int k = 0; k < 100 && ops.size() < 10; k++) begin
            step(1'b1, rand_cmd(), DATA_W'($urandom), 4'($urandom));
        end
        idle_steps(30);
        chk("wrap_done_total", 64'(dut_done_cnt), 64'(10));
        chk("wrap_count_le_depth", 64'(max_cnt <= int'(FIFO_DEPTH)), 64'(1));

        // Reset asserted during EXEC with two commands queued.
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, mk_cmd(k + 1, k + 2, k + 5, k), 32'h0, 4'h0);
        for (int k = 0; k < 10 && bus.alu_en !== 1'b1; k++) step(1'b0, cz, 32'h0, 4'h0);
        chk("rst_exec_reached", 64'(bus.alu_en), 64'(1));
        chk("rst_exec_queued", 64'(bus.fifo_count), 64'(2));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_alu_en",   64'(bus.alu_en),     64'(0));
        chk("rst_w_en",     64'(bus.w_en),       64'(0));
        chk("rst_done",     64'(bus.done),       64'(0));
        chk("rst_r_addr_a", 64'(bus.r_addr_a),   64'(0));
        chk("rst_w_addr",   64'(bus.w_addr),     64'(0));
        chk("rst_alu_op",   64'(bus.alu_op),     64'(0));
        chk("rst_count",    64'(bus.fifo_count), 64'(0));
        chk("rst_busy",     64'(bus.busy),       64'(0));
        chk("rst_ready",    64'(bus.cmd_ready),  64'(1));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_w_en", 64'(bus.w_en), 64'(0));
            chk("rst_hold_done", 64'(bus.done), 64'(0));
        end
        rst = 1'b0;
        model_reset();
        idle_steps(8);

        // Randomized traffic at several offered loads.
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            pct = (ph % 3 == 0) ? 25 : ((ph % 3 == 1) ? 60 : 100);
            for (int k = 0; k < 100; k++) begin
                step($urandom_range(0, 99) < pct, rand_cmd(), DATA_W'($urandom), 4'($urandom));
            end
        end
        idle_steps(20);
        chk("rand_done_total", 64'(dut_done_cnt), 64'(ops.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
